// File: rtl/key_debouncer.sv
// Key/switch debouncer: 2-flop synchroniser, stability-qualified
// level FSM and a saturating rejected-bounce counter.
module key_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20,
  parameter int GLITCH_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in,
  input  logic                    glitch_clr,
  output logic                    out,
  output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

  logic                    s1_q;
  logic                    s2_q;
  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic                    out_q;
  logic                    out_d;
  logic [GLITCH_WIDTH-1:0] glitch_q;
  logic [GLITCH_WIDTH-1:0] glitch_d;
  logic                    abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= S_LOW;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      s1_q     <= in;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (s2_q) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = S_LOW;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s2_q) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (s2_q) begin
          state_d = S_HIGH;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // out is registered from the next state so it moves with the FSM
  always_comb begin
    out_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
  end

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (abort && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  assign out        = out_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_CYCLES=4,
// GLITCH_WIDTH=3. Inputs change and outputs are sampled on negedge.
module tb_key_debouncer;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       glitch_clr;
  logic       out;
  logic [2:0] glitch_cnt;

  int n_checks;
  int n_fails;

  key_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_WIDTH(20),
    .GLITCH_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .glitch_clr(glitch_clr),
    .out(out),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_out: got %b want 0", out);
    end
    n_checks++;
    if (glitch_cnt !== 3'd0) begin
      n_fails++;
      $display("FAIL reset_glitch: got %0d want 0", glitch_cnt);
    end
    rst_n = 1'b1;
    tick(2);
    // short pulse to leave a nonzero glitch count behind
    in = 1'b1;
    tick(2);
    in = 1'b0;
    tick(4);
    n_checks++;
    if (glitch_cnt !== 3'd1) begin
      n_fails++;
      $display("FAIL pre_reset_glitch: got %0d want 1", glitch_cnt);
    end
    in = 1'b1;
    tick(4);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL async_reset_out: got %b want 0", out);
    end
    n_checks++;
    if (glitch_cnt !== 3'd0) begin
      n_fails++;
      $display("FAIL async_reset_glitch: got %0d want 0",
               glitch_cnt);
    end
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL release_early: got %b want 0", out);
    end
    tick(1);
    n_checks++;
    if (out !== 1'b1) begin
      n_fails++;
      $display("FAIL release_rise: got %b want 1", out);
    end
  endtask

  task automatic test_clean_press;
    in = 1'b0;
    tick(6);
    n_checks++;
    if (out !== 1'b1) begin
      n_fails++;
      $display("FAIL release_hold: got %b want 1", out);
    end
    tick(1);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL release_fall: got %b want 0", out);
    end
    in = 1'b1;
    tick(6);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL press_early: got %b want 0", out);
    end
    tick(1);
    n_checks++;
    if (out !== 1'b1) begin
      n_fails++;
      $display("FAIL press_rise: got %b want 1", out);
    end
    in = 1'b0;
    tick(7);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL press_fall: got %b want 0", out);
    end
    n_checks++;
    if (glitch_cnt !== 3'd0) begin
      n_fails++;
      $display("FAIL clean_glitch: got %0d want 0", glitch_cnt);
    end
  endtask

  task automatic test_boundary;
    in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if (out !== 1'b0) begin
        n_fails++;
        $display("FAIL b4_out_hi[%0d]: got %b want 0", i, out);
      end
    end
    in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_checks++;
      if (out !== 1'b0) begin
        n_fails++;
        $display("FAIL b4_out_lo[%0d]: got %b want 0", i, out);
      end
    end
    n_checks++;
    if (glitch_cnt !== 3'd1) begin
      n_fails++;
      $display("FAIL b4_glitch: got %0d want 1", glitch_cnt);
    end
    in = 1'b1;
    tick(5);
    in = 1'b0;
    tick(2);
    n_checks++;
    if (out !== 1'b1) begin
      n_fails++;
      $display("FAIL b5_rise: got %b want 1", out);
    end
    tick(6);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL b5_fall: got %b want 0", out);
    end
    n_checks++;
    if (glitch_cnt !== 3'd1) begin
      n_fails++;
      $display("FAIL b5_glitch: got %0d want 1", glitch_cnt);
    end
  endtask

  task automatic test_bounce;
    logic [4:0] pat;
    pat = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      in = pat[i];
      if (i != 0) tick(2);
    end
    tick(6);
    n_checks++;
    if (out !== 1'b0) begin
      n_fails++;
      $display("FAIL bounce_early: got %b want 0", out);
    end
    n_checks++;
    if (glitch_cnt !== 3'd3) begin
      n_fails++;
      $display("FAIL bounce_glitch: got %0d want 3", glitch_cnt);
    end
    tick(1);
    n_checks++;
    if (out !== 1'b1) begin
      n_fails++;
      $display("FAIL bounce_rise: got %b want 1", out);
    end
    in = 1'b0;
    tick(2);
    in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_checks++;
      if (out !== 1'b1) begin
        n_fails++;
        $display("FAIL dip_out[%0d]: got %b want 1", i, out);
      end
    end
    n_checks++;
    if (glitch_cnt !== 3'd4) begin
      n_fails++;
      $display("FAIL dip_glitch: got %0d want 4", glitch_cnt);
    end
  endtask

  task automatic test_saturation;
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    n_checks++;
    if (glitch_cnt !== 3'd0) begin
      n_fails++;
      $display("FAIL clr: got %0d want 0", glitch_cnt);
    end
    for (int i = 1; i <= 9; i++) begin
      in = 1'b0;
      tick(2);
      in = 1'b1;
      tick(4);
      n_checks++;
      if (glitch_cnt !== 3'((i > 7) ? 7 : i)) begin
        n_fails++;
        $display("FAIL sat[%0d]: got %0d want %0d", i, glitch_cnt,
                 (i > 7) ? 7 : i);
      end
    end
    n_checks++;
    if (out !== 1'b1) begin
      n_fails++;
      $display("FAIL sat_out: got %b want 1", out);
    end
    // clear lands on the same edge as the abort
    in = 1'b0;
    tick(2);
    in = 1'b1;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    n_checks++;
    if (glitch_cnt !== 3'd0) begin
      n_fails++;
      $display("FAIL clr_vs_inc: got %0d want 0", glitch_cnt);
    end
    tick(1);
    n_checks++;
    if (glitch_cnt !== 3'd0) begin
      n_fails++;
      $display("FAIL clr_hold: got %0d want 0", glitch_cnt);
    end
    in = 1'b0;
    tick(2);
    in = 1'b1;
    tick(4);
    n_checks++;
    if (glitch_cnt !== 3'd1) begin
      n_fails++;
      $display("FAIL post_clr_inc: got %0d want 1", glitch_cnt);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst_n      = 1'b0;
    in         = 1'b0;
    glitch_clr = 1'b0;
    test_reset();
    test_clean_press();
    test_boundary();
    test_bounce();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
